// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: imem port, pipeline control inputs and IF/ID / status outputs.
interface instr_fetch_unit_if import fetch_pkg::*; ();

    logic [XLEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_rdata;
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            halt_req;
    logic            if_id_valid;
    logic [ILEN-1:0] if_id_instr;
    logic [XLEN-1:0] if_id_pc;
    logic [XLEN-1:0] if_id_pc_plus4;
    logic            fetch_fault;
    logic [XLEN-1:0] fault_addr;
    logic            halted;
    logic [31:0]     fetch_count;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  stall,
        input  redirect_valid,
        input  redirect_target,
        input  halt_req,
        output if_id_valid,
        output if_id_instr,
        output if_id_pc,
        output if_id_pc_plus4,
        output fetch_fault,
        output fault_addr,
        output halted,
        output fetch_count
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output stall,
        output redirect_valid,
        output redirect_target,
        output halt_req,
        input  if_id_valid,
        input  if_id_instr,
        input  if_id_pc,
        input  if_id_pc_plus4,
        input  fetch_fault,
        input  fault_addr,
        input  halted,
        input  fetch_count
    );

endinterface

// File: rtl/instr_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats load; with neither asserted it holds.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [ILEN-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            flush,
    input  logic [ILEN-1:0] fetch_instr,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            valid,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values; the missing final else is a clock enable, not a latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            instr    <= NOP_INSTR;
            pc       <= '0;
            pc_plus4 <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= fetch_instr;
            pc       <= fetch_pc;
            pc_plus4 <= fetch_pc + 32'd4;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, next-PC select, fault detection and BOOT/RUN/HALT control.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned     IMEM_WORDS   = 20,
    parameter logic [ILEN-1:0] NOP_INSTR    = fetch_pkg::NOP_INSTR
) (
    input logic                 clk,
    input logic                 rst_n,
    instr_fetch_unit_if.master  bus
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic            fetch_fault;
    logic [XLEN-1:0] fault_addr;
    logic [31:0]     fetch_count;

    logic out_of_range;
    logic ifid_load;
    logic ifid_flush;

    assign out_of_range = 32'({2'b00, pc[XLEN-1:2]}) >= 32'(IMEM_WORDS);

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        case (state)
            S_RUN: begin
                if (bus.halt_req || bus.redirect_valid) begin
                    ifid_flush = 1'b1;
                end else if (!bus.stall) begin
                    if (out_of_range) ifid_flush = 1'b1;
                    else              ifid_load  = 1'b1;
                end
            end
            S_HALT:  ifid_flush = 1'b1;
            default: ;
        endcase
    end

    // Only the first fault is recorded; reaching S_HALT makes later faults impossible anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_BOOT;
            pc          <= RESET_VECTOR;
            fetch_fault <= 1'b0;
            fault_addr  <= '0;
            fetch_count <= '0;
        end else begin
            case (state)
                S_BOOT: state <= S_RUN;
                S_RUN: begin
                    if (bus.halt_req) begin
                        state <= S_HALT;
                    end else if (bus.redirect_valid) begin
                        if (is_misaligned(bus.redirect_target)) begin
                            state       <= S_HALT;
                            fetch_fault <= 1'b1;
                            if (!fetch_fault) fault_addr <= bus.redirect_target;
                        end else begin
                            pc <= bus.redirect_target;
                        end
                    end else if (!bus.stall) begin
                        if (out_of_range) begin
                            state       <= S_HALT;
                            fetch_fault <= 1'b1;
                            if (!fetch_fault) fault_addr <= pc;
                        end else begin
                            pc          <= pc + 32'd4;
                            fetch_count <= fetch_count + 32'd1;
                        end
                    end
                end
                S_HALT:  ;
                default: state <= S_HALT;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (ifid_load),
        .flush       (ifid_flush),
        .fetch_instr (bus.imem_rdata),
        .fetch_pc    (pc),
        .valid       (bus.if_id_valid),
        .instr       (bus.if_id_instr),
        .pc          (bus.if_id_pc),
        .pc_plus4    (bus.if_id_pc_plus4)
    );

    assign bus.imem_addr   = pc;
    assign bus.fetch_fault = fetch_fault;
    assign bus.fault_addr  = fault_addr;
    assign bus.halted      = (state == S_HALT);
    assign bus.fetch_count = fetch_count;

endmodule
